// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared raster-timing definitions for the VGA timing generator and the
// sprite blocks (ball, paddle) that consume its scan coordinates.
//   - Default 640x480@60 timing constants
//   - h_total / v_total helpers that add up the line and frame lengths
//   - width_of: counter width for a range 0..n-1 (never narrower than 1 bit)
//   - coord_t: screen-coordinate type shared with the sprite blocks
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned DEF_ACTIVE_COLS    = 640;
  localparam int unsigned DEF_ACTIVE_ROWS    = 480;
  localparam int unsigned DEF_H_FRONT        = 16;
  localparam int unsigned DEF_H_SYNC         = 96;
  localparam int unsigned DEF_H_BACK         = 48;
  localparam int unsigned DEF_V_FRONT        = 10;
  localparam int unsigned DEF_V_SYNC         = 2;
  localparam int unsigned DEF_V_BACK         = 33;
  localparam int unsigned DEF_CLKS_PER_PIXEL = 1;

  // Wide enough for any column or row of the default screen.
  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic int unsigned h_total(input int unsigned cols, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return cols + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned rows, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return rows + front + sync + back;
  endfunction

  // A modulus of 1 still needs a 1-bit register to exist.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Raster output bundle of the timing generator.
//   pixel_en   : one-clk strobe per pixel slot
//   row / col  : visible scan coordinate, 0 during blanking
//   active     : inside the visible window
//   hsync/vsync: active-low sync pulses
//   frame_tick : one-clk pulse at the start of vertical blanking
// Modports: master drives the bundle (timing generator), slave reads it
// (sprites, compositor, VGA pins).
// ---------------------------------------------------------------------------
interface vga_timing_if #(
  parameter int unsigned ROW_W = 9,
  parameter int unsigned COL_W = 10
);

  logic             pixel_en;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             active;
  logic             hsync;
  logic             vsync;
  logic             frame_tick;

  modport master (
    output pixel_en, row, col, active, hsync, vsync, frame_tick
  );

  modport slave (
    input pixel_en, row, col, active, hsync, vsync, frame_tick
  );

endinterface

// File: rtl/vga_timing_mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Enabled modulo-MODULUS counter used for the pixel divider and the
// horizontal and vertical scan counters.
//   clk   : system clock
//   reset : synchronous, active-high; clears the count
//   en    : advance by one on this clk
//   count : current value, 0..MODULUS-1
//   wrap  : en is high while count sits at MODULUS-1 (count returns to 0)
// ---------------------------------------------------------------------------
module mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned W       = width_of(MODULUS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max;

  assign at_max = (count_q == W'(MODULUS - 1));

  // Next count: hold unless enabled, then step or fold back to zero.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = at_max ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en & at_max;

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Raster timing generator: pixel divider, horizontal/vertical scan counters
// and the sync / active / coordinate / frame-tick decode.
//   clk    : system clock
//   reset  : synchronous, active-high; counters restart at the top-left pixel
//   vga_o  : vga_timing_if master (pixel_en, row, col, active, hsync, vsync,
//            frame_tick)
// Build option VGA_TIMING_REG_OUT_EN: when defined, row, col, active, hsync,
// vsync and frame_tick pass through one output register (one clk later) to
// line up with a registered pixel-colour stage; pixel_en is never delayed.
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE_COLS    = DEF_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS    = DEF_ACTIVE_ROWS,
  parameter int unsigned H_FRONT        = DEF_H_FRONT,
  parameter int unsigned H_SYNC         = DEF_H_SYNC,
  parameter int unsigned H_BACK         = DEF_H_BACK,
  parameter int unsigned V_FRONT        = DEF_V_FRONT,
  parameter int unsigned V_SYNC         = DEF_V_SYNC,
  parameter int unsigned V_BACK         = DEF_V_BACK,
  parameter int unsigned CLKS_PER_PIXEL = DEF_CLKS_PER_PIXEL
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_if.master  vga_o
);

  localparam int unsigned H_TOTAL = h_total(ACTIVE_COLS, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(ACTIVE_ROWS, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DIV_W   = width_of(CLKS_PER_PIXEL);
  localparam int unsigned H_W     = width_of(H_TOTAL);
  localparam int unsigned V_W     = width_of(V_TOTAL);
  localparam int unsigned ROW_W   = width_of(ACTIVE_ROWS);
  localparam int unsigned COL_W   = width_of(ACTIVE_COLS);

  logic [DIV_W-1:0] div_cnt;
  logic             pixel_en;
  logic [H_W-1:0]   h_cnt;
  logic             h_wrap;
  logic [V_W-1:0]   v_cnt;
  logic             v_wrap_unused;

  mod_counter #(.MODULUS(CLKS_PER_PIXEL)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (div_cnt),
    .wrap  (pixel_en)
  );

  mod_counter #(.MODULUS(H_TOTAL)) u_h (
    .clk   (clk),
    .reset (reset),
    .en    (pixel_en),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  // Steps only on the last pixel of a line, so it wraps on the same clk as h.
  mod_counter #(.MODULUS(V_TOTAL)) u_v (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap_unused)
  );

  // Compare in 32 bits so window edges equal to the totals cannot overflow.
  int unsigned h_val;
  int unsigned v_val;
  assign h_val = 32'(h_cnt);
  assign v_val = 32'(v_cnt);

  logic             active_d;
  logic             hsync_d;
  logic             vsync_d;
  logic             frame_tick_d;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;

  // Zero-latency decode of the counter registers. frame_tick also requires
  // div_cnt==0 so that it marks only the first clk of the h=0 pixel when a
  // pixel spans several clks.
  always_comb begin
    active_d     = (h_val < ACTIVE_COLS) && (v_val < ACTIVE_ROWS);
    hsync_d      = !((h_val >= ACTIVE_COLS + H_FRONT) &&
                     (h_val <  ACTIVE_COLS + H_FRONT + H_SYNC));
    vsync_d      = !((v_val >= ACTIVE_ROWS + V_FRONT) &&
                     (v_val <  ACTIVE_ROWS + V_FRONT + V_SYNC));
    frame_tick_d = (h_val == 0) && (v_val == ACTIVE_ROWS) && (div_cnt == '0);
    row_d        = '0;
    col_d        = '0;
    if (active_d) begin
      row_d = v_cnt[ROW_W-1:0];
      col_d = h_cnt[COL_W-1:0];
    end
  end

  assign vga_o.pixel_en = pixel_en;

`ifdef VGA_TIMING_REG_OUT_EN
  logic             active_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             frame_tick_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  // One-clk output stage; reset leaves the screen blank with syncs idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
    end else begin
      active_q     <= active_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
      row_q        <= row_d;
      col_q        <= col_d;
    end
  end

  assign vga_o.active     = active_q;
  assign vga_o.hsync      = hsync_q;
  assign vga_o.vsync      = vsync_q;
  assign vga_o.frame_tick = frame_tick_q;
  assign vga_o.row        = row_q;
  assign vga_o.col        = col_q;
`else
  assign vga_o.active     = active_d;
  assign vga_o.hsync      = hsync_d;
  assign vga_o.vsync      = vsync_d;
  assign vga_o.frame_tick = frame_tick_d;
  assign vga_o.row        = row_d;
  assign vga_o.col        = col_d;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
// Bench for vga_timing using a shrunken screen so whole frames fit in a short
// run: 8x4 visible, H porches 2/3/2 (15 pixels per line), V porches 1/2/1
// (8 lines per frame). dut1 runs one clk per pixel, dut2 two clks per pixel.
// Cycle numbers below count clks since reset release (0 = first clk after).
//   dut1: line 15 clks, frame 120 clks, hsync low h=10..12, vsync low v=5..6,
//         frame_tick at h=0 v=4 -> clk 60.
//   dut2: line 30 clks, frame 240 clks, frame_tick at clk 120.
// Works with or without VGA_TIMING_REG_OUT_EN (LAT shifts the decode timing).
// ---------------------------------------------------------------------------
module tb_vga_timing;
  import vga_pkg::*;

  localparam int unsigned AC = 8, AR = 4, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VF = 1, VS = 2, VB = 1;
  localparam int unsigned ROW_W = width_of(AR);
  localparam int unsigned COL_W = width_of(AC);
`ifdef VGA_TIMING_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct { int kind; int cyc; } event_t;
  typedef struct { int cyc; int val; } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus1 ();
  vga_timing_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus2 ();

  vga_timing #(.ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
               .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLKS_PER_PIXEL(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .vga_o (bus1)
  );

  vga_timing #(.ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
               .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLKS_PER_PIXEL(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .vga_o (bus2)
  );

  event_t evQ[$];
  snap_t  snapQ[$];
  int     relCyc = 0;
  int     chkCnt = 0;
  int     errCnt = 0;
  int     drainSeq = 0;
  int     drainSeen = 0;
  int     actCnt1 = 0;
  logic   prevFt1 = 1'b0, prevHs1 = 1'b1, prevVs1 = 1'b1;
  logic   prevFt2 = 1'b0, prevHs2 = 1'b1, prevVs2 = 1'b1;

  // Clks since reset release, restarted by every reset.
  always @(posedge clk) begin
    if (reset) relCyc <= 0;
    else       relCyc <= relCyc + 1;
  end

  // Hand-derived first occurrence and repeat period of each watched event.
  function automatic int evBase(input int kind);
    case (kind)
      0: return 60;   1: return 10;  2: return 13;  3: return 75;
      4: return 105;  5: return 120; 6: return 20;  default: return 150;
    endcase
  endfunction

  function automatic int evPeriod(input int kind);
    case (kind)
      0: return 120;  1: return 15;  2: return 15;  3: return 120;
      4: return 120;  5: return 240; 6: return 30;  default: return 240;
    endcase
  endfunction

  function automatic string evName(input int kind);
    case (kind)
      0: return "tick1";   1: return "hsFall1"; 2: return "hsRise1"; 3: return "vsFall1";
      4: return "vsRise1"; 5: return "tick2";   6: return "hsFall2"; default: return "vsFall2";
    endcase
  endfunction

  function automatic int packSnap(input int row, input int col, input int act,
                                  input int hs, input int vs);
    return (row << 6) | (col << 3) | (act << 2) | (hs << 1) | vs;
  endfunction

  task automatic pushEvents(input int runLen);
    event_t e;
    for (int kind = 0; kind < 8; kind++) begin
      for (int c = evBase(kind) + LAT; c < runLen; c += evPeriod(kind)) begin
        e.kind = kind;
        e.cyc  = c;
        evQ.push_back(e);
      end
    end
  endtask

  task automatic pushSnap(input int cyc, input int row, input int col, input int act,
                          input int hs, input int vs);
    snap_t s;
    s.cyc = cyc;
    s.val = packSnap(row, col, act, hs, vs);
    snapQ.push_back(s);
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    chkCnt++;
    if (got != exp) begin
      errCnt++;
      $display("[TB] FAIL %s at clk %0d: got 0x%0h, expected 0x%0h", name, relCyc, got, exp);
    end
  endtask

  // Matches an observed event against the earliest expected one of its kind.
  task automatic popCheck(input int kind);
    int idx = -1;
    for (int i = 0; i < evQ.size(); i++) begin
      if (evQ[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      checkOutput({evName(kind), "Unexpected"}, relCyc, -1);
    end else begin
      checkOutput(evName(kind), relCyc, evQ[idx].cyc);
      evQ.delete(idx);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (drainSeq != drainSeen) begin
      drainSeen = drainSeq;
      checkOutput("eventsLeft", evQ.size(), 0);
      checkOutput("snapsLeft", snapQ.size(), 0);
      if (drainSeq == 1) checkOutput("activeClksPerFrame", actCnt1, AR * AC);
      evQ.delete();
      snapQ.delete();
    end
    if (!reset) begin
      if (snapQ.size() > 0 && snapQ[0].cyc == relCyc) begin
        checkOutput("snapshot", packSnap(int'(bus1.row), int'(bus1.col), int'(bus1.active),
                                         int'(bus1.hsync), int'(bus1.vsync)), snapQ[0].val);
        void'(snapQ.pop_front());
      end
      if (bus1.frame_tick && !prevFt1) popCheck(0);
      if (prevFt1) checkOutput("tick1Width", int'(bus1.frame_tick), 0);
      if (prevHs1 && !bus1.hsync) popCheck(1);
      if (!prevHs1 && bus1.hsync) popCheck(2);
      if (prevVs1 && !bus1.vsync) popCheck(3);
      if (!prevVs1 && bus1.vsync) popCheck(4);
      if (bus2.frame_tick && !prevFt2) popCheck(5);
      if (prevFt2) checkOutput("tick2Width", int'(bus2.frame_tick), 0);
      if (prevHs2 && !bus2.hsync) popCheck(6);
      if (prevVs2 && !bus2.vsync) popCheck(7);
      checkOutput("pixelEn1", int'(bus1.pixel_en), 1);
      checkOutput("pixelEn2", int'(bus2.pixel_en), relCyc % 2);
      if (bus1.active && relCyc >= LAT && relCyc < 120 + LAT) actCnt1++;
    end
    prevFt1 = bus1.frame_tick;
    prevHs1 = bus1.hsync;
    prevVs1 = bus1.vsync;
    prevFt2 = bus2.frame_tick;
    prevHs2 = bus2.hsync;
    prevVs2 = bus2.vsync;
  end

  // Holds reset for holdClks, runs runLen clks, then re-asserts reset and
  // asks the monitor to confirm every expectation was consumed.
  task automatic applyStimulus(input int holdClks, input int runLen);
    repeat (holdClks) @(posedge clk);
    pushEvents(runLen);
    #2 reset = 1'b0;
    repeat (runLen) @(posedge clk);
    #2 reset = 1'b1;
    drainSeq++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Two full frames of dut1 after a 3-clk reset.
    pushSnap(0, 0, 0, (LAT == 0) ? 1 : 0, 1, 1);
    pushSnap(5 + LAT,   0, 5, 1, 1, 1);
    pushSnap(11 + LAT,  0, 0, 0, 0, 1);
    pushSnap(13 + LAT,  0, 0, 0, 1, 1);
    pushSnap(22 + LAT,  1, 7, 1, 1, 1);
    pushSnap(23 + LAT,  0, 0, 0, 1, 1);
    pushSnap(52 + LAT,  3, 7, 1, 1, 1);
    pushSnap(67 + LAT,  0, 0, 0, 1, 1);
    pushSnap(76 + LAT,  0, 0, 0, 1, 0);
    pushSnap(106 + LAT, 0, 0, 0, 1, 1);
    pushSnap(130 + LAT, 0, 0, 0, 0, 1);
    applyStimulus(3, 260);

    // Run into line 2 (h=5 at the last clk) so the next reset lands mid-frame.
    pushSnap(0, 0, 0, (LAT == 0) ? 1 : 0, 1, 1);
    pushSnap(34 + LAT, 2, 4, 1, 1, 1);
    applyStimulus(2, 36);

    // One-clk reset: counters restart at 0,0 and the tick comes 60 clks later.
    pushSnap(0, 0, 0, (LAT == 0) ? 1 : 0, 1, 1);
    pushSnap(3 + LAT, 0, 3, 1, 1, 1);
    applyStimulus(1, 130);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", chkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
Raster timing generator that produces the row/col scan coordinates consumed by the ball and paddle pixel-query blocks, plus VGA hsync/vsync and an active-video flag.
- Owns horizontal/vertical counters, advanced on a divided pixel enable.
- Emits a once-per-frame tick so game objects can step motion per frame instead of free-running clock counts.
- Sits between the clock source and all sprite/compositor logic.

Parameters:
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLKS_PER_PIXEL, 1, clk cycles per pixel; 2 for 50 MHz clk to 25 MHz pixel rate

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixel_en  out  1  one-clk strobe marking each pixel slot
row  out  $clog2(ACTIVE_ROWS)  current visible line; 0 during blanking
col  out  $clog2(ACTIVE_COLS)  current visible pixel; 0 during blanking
active  out  1  high when h_cnt<ACTIVE_COLS and v_cnt<ACTIVE_ROWS
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
frame_tick  out  1  one-clk pulse at start of vertical blanking

Behaviour:
- Fixed interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Derived totals: H_TOTAL = ACTIVE_COLS+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = ACTIVE_ROWS+V_FRONT+V_SYNC+V_BACK (525).

Pixel divider:
- div counts 0..CLKS_PER_PIXEL-1 and wraps.
- pixel_en = (div == CLKS_PER_PIXEL-1).
- With CLKS_PER_PIXEL=1, pixel_en is constantly 1 after reset.

Counters:
- h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1, both advance only on pixel_en.
- h_cnt wraps at H_TOTAL-1 to 0; v_cnt increments on that wrap.
- v_cnt wraps at V_TOTAL-1 to 0 on the same clk as h_cnt wraps.
- Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL); no overflow beyond the totals.

Decode (combinational from counter registers, zero latency):
- hsync = 0 iff ACTIVE_COLS+H_FRONT <= h_cnt < ACTIVE_COLS+H_FRONT+H_SYNC.
- vsync = 0 iff ACTIVE_ROWS+V_FRONT <= v_cnt < ACTIVE_ROWS+V_FRONT+V_SYNC.
- row/col = truncated counters when active, else 0.
- frame_tick = 1 for exactly one clk, the first clk where h_cnt==0 and v_cnt==ACTIVE_ROWS; held exactly one clk even when CLKS_PER_PIXEL>1.

Reset:
- div, h_cnt, v_cnt = 0.
- Resulting outputs: hsync=1, vsync=1, active=1, row=col=0, frame_tick=0, pixel_en=(CLKS_PER_PIXEL==1).
- Reset asserted mid-frame wins over all counting; counters read 0 the clk after reset is sampled.
- First pixel_en after deassertion occurs CLKS_PER_PIXEL-1 clks later.

Optional Feature:
Macro VGA_TIMING_REG_OUT_EN.
- Defined: row, col, active, hsync, vsync, frame_tick each pass through one output register, giving one clk of latency, so sync aligns with a registered pixel-colour stage downstream. The register's reset values are active=0, hsync=1, vsync=1, row=col=0, frame_tick=0. pixel_en is not delayed.
- Undefined: outputs are combinational from the counter registers with zero latency, as described above.

Decomposition:
- Package vga_pkg: default timing constants (640x480@60 values above), H_TOTAL/V_TOTAL helper functions, and a screen-coordinate width typedef shared with the ball/paddle blocks.
- One natural sub-module: mod_counter (parameter MODULUS; inputs clk, reset, en; outputs count, wrap). Instantiate three times: divider, horizontal, vertical.

Test Plan:
- Reset, defaults: hold reset 3 clks, release -> hsync=vsync=1, active=1, row=col=0, pixel_en=1 from the first clk.
- Horizontal timing, CLKS_PER_PIXEL=1: hsync falls at h_cnt 656 and rises at 752; hsync falling edges are 800 clks apart; active is high for exactly 640 clks per visible line.
- Vertical timing: vsync low for lines 490-491 (1600 clks). Frame period 420000 clks. 307200 active clks per frame. frame_tick once per frame, at h=0, v=480.
- CLKS_PER_PIXEL=2: pixel_en toggles every other clk; line = 1600 clks; frame_tick still exactly 1 clk wide.
- Mid-frame reset at v=200, h=300: the clk after reset, counters read 0,0. Next frame_tick arrives exactly 480*800 clks after release.
- With VGA_TIMING_REG_OUT_EN: every output edge lags the undefined build by exactly 1 clk; active=0 in the first clk after reset.
